// File: rtl/serial_mag_comp_pkg.sv
// rtl/serial_mag_comp_pkg.sv - shared state and relation encodings for serial_mag_comp
// Purpose: FSM state encoding used by the comparator and relation codes used by
//          anything that scores comparator results.
// Ports:   none (package).
package serial_mag_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    // Flag vector {eq, gt, lt} that corresponds to a relation code.
    function automatic logic [2:0] rel_flags(input rel_t rel);
        case (rel)
            REL_EQ:  return 3'b100;
            REL_GT:  return 3'b010;
            REL_LT:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// rtl/serial_mag_comp_if.sv - operand/result bundle for serial_mag_comp
// Purpose: groups the serial operand inputs and the status/result outputs.
// Ports:   start, bit_valid, a_bit, b_bit (master -> slave);
//          ready, busy, done, eq, gt, lt (slave -> master).
interface serial_mag_comp_if;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic ready;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  ready, busy, done, eq, gt, lt
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output ready, busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_mag_comp_beat_counter.sv
// rtl/serial_mag_comp_beat_counter.sv - beat counter for the serial comparator
// Purpose: counts accepted beats of a frame and flags the final one.
// Ports:   clk, rst (sync, active-high), clr (restart count), en (beat accepted)
//          -> cnt (beats accepted so far), last (en on the WIDTH-th beat).
module serial_beat_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     last
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    assign last = en & (cnt == LAST_CNT);

    // Wrap to zero after the last beat so non-power-of-two widths never overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first unsigned magnitude comparator
// Purpose: compares two WIDTH-bit operands delivered one bit pair per beat and
//          reports registered eq/gt/lt with a one-cycle done strobe.
// Ports:   clk, rst (sync, active-high);
//          bus (slave): start, bit_valid, a_bit, b_bit in;
//                       ready, busy, done, eq, gt, lt out (all registered).
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_mag_comp_if.slave  bus
);
    import serial_mag_comp_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             decided_q, pend_gt_q;
    logic             ready_q, busy_q, done_q, eq_q, gt_q, lt_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             clr, beat;
    logic             dec_d, gt_d;

    assign clr  = (state_q == ST_IDLE) && bus.start;
    assign beat = (state_q == ST_RUN) && bus.bit_valid;

    serial_beat_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (beat),
        .cnt  (cnt),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        // The first differing bit (MSB first) fixes the answer; later beats only keep framing.
        // On beat 0 no earlier decision can exist, whatever the registers hold.
        dec_d = ((cnt == '0) ? 1'b0 : decided_q) | (bus.a_bit ^ bus.b_bit);
        gt_d  = (decided_q && (cnt != '0)) ? pend_gt_q : bus.a_bit;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            decided_q <= 1'b0;
            pend_gt_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            if (clr) begin
                decided_q <= 1'b0;
                pend_gt_q <= 1'b0;
                eq_q      <= 1'b0;
                gt_q      <= 1'b0;
                lt_q      <= 1'b0;
            end else if (beat) begin
                decided_q <= dec_d;
                pend_gt_q <= gt_d;
                // Flags land on the edge into DONE so they are valid with done.
                if (last) begin
                    eq_q <= ~dec_d;
                    gt_q <= dec_d & gt_d;
                    lt_q <= dec_d & ~gt_d;
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.eq    = eq_q;
    assign bus.gt    = gt_q;
    assign bus.lt    = lt_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - self-checking bench for serial_mag_comp
module tb_serial_mag_comp;
    import serial_mag_comp_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_mag_comp_if bus ();

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned comparison, mapped to {eq, gt, lt}.
    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
        if (a == b)     return rel_flags(REL_EQ);
        else if (a > b) return rel_flags(REL_GT);
        else            return rel_flags(REL_LT);
    endfunction

    function automatic logic [7:0] flags();
        return {5'd0, bus.eq, bus.gt, bus.lt};
    endfunction

    // One full frame. restart_at: beat index at which a stray start is pulsed (-1 none).
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input int stalls,
                         input int restart_at, input bit start_in_done, input string tag);
        logic [2:0] exp;
        exp = model(a, b);
        check({tag, " ready_before_start"}, {7'd0, bus.ready}, 8'd1);
        // Bits presented in the start cycle must be ignored.
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
        step();
        bus.start = 1'b0; bus.bit_valid = 1'b0;
        check({tag, " after_start rdy/busy/done"},
              {5'd0, bus.ready, bus.busy, bus.done}, 8'b010);
        check({tag, " flags_cleared"}, flags(), 8'd0);
        for (int i = W - 1; i >= 0; i--) begin
            for (int s = 0; s < stalls; s++) begin
                step();
                check({tag, " stall busy/done"}, {6'd0, bus.busy, bus.done}, 8'b10);
            end
            bus.bit_valid = 1'b1;
            bus.a_bit     = a[i];
            bus.b_bit     = b[i];
            bus.start     = ((W - 1 - i) == restart_at);
            step();
            bus.bit_valid = 1'b0;
            bus.start     = 1'b0;
            if (i > 0)
                check({tag, " beat busy/done"}, {6'd0, bus.busy, bus.done}, 8'b10);
        end
        check({tag, " done_cycle rdy/busy/done"},
              {5'd0, bus.ready, bus.busy, bus.done}, 8'b001);
        check({tag, " result"}, flags(), {5'd0, exp});
        bus.start = start_in_done;
        step();
        bus.start = 1'b0;
        check({tag, " after_done rdy/busy/done"},
              {5'd0, bus.ready, bus.busy, bus.done}, 8'b100);
        check({tag, " result_held"}, flags(), {5'd0, exp});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [7:0] pa;
        logic [7:0] pb;
        rst = 1'b1;
        bus.start = 1'b0; bus.bit_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
        step();
        step();
        check("reset rdy/busy/done", {5'd0, bus.ready, bus.busy, bus.done}, 8'b100);
        check("reset flags", flags(), 8'd0);
        rst = 1'b0;
        step();

        frame(8'hA5, 8'hA5, 0, -1, 1'b0, "equal");
        frame(8'h80, 8'h7F, 0, -1, 1'b0, "msb_decides");
        frame(8'h12, 8'h13, 2, -1, 1'b0, "lsb_stalls");

        // Reset in the middle of a frame.
        pa = 8'hFF; pb = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = W - 1; i >= W - 4; i--) begin
            bus.bit_valid = 1'b1; bus.a_bit = pa[i]; bus.b_bit = pb[i];
            step();
        end
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst rdy/busy/done", {5'd0, bus.ready, bus.busy, bus.done}, 8'b100);
        check("midrst flags", flags(), 8'd0);
        for (int i = 0; i < 6; i++) begin
            bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
            step();
            check("midrst no_done", {7'd0, bus.done}, 8'd0);
        end
        bus.bit_valid = 1'b0;
        frame(8'h01, 8'h02, 0, -1, 1'b0, "after_rst");

        frame(8'h40, 8'h20, 0, 3, 1'b0, "start_while_busy");
        frame(8'h00, 8'h00, 0, -1, 1'b0, "b2b_first");
        frame(8'hFF, 8'hFE, 0, -1, 1'b1, "b2b_second");
        step();

        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            if (n % 5 == 4) rb = ra ^ 8'h01;
            frame(ra, rb, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
